// File: rtl/sp_types_pkg.sv
// rtl/sp_types_pkg.sv - shared types for the scratchpad DRAM-store path
package sp_types_pkg;

  localparam logic [31:0] SP_STRIDE = 32'd32;
  localparam int          SP_ADDR_W = 32;
  localparam int          SP_ROW_W  = 2;
  localparam int          SP_DATA_W = 64;

  // One dramFIFO entry: a single row of an output tile.
  typedef struct packed {
    logic [SP_ADDR_W-1:0] addr;
    logic [SP_ROW_W-1:0]  row_s;
    logic [SP_DATA_W-1:0] data;
  } dramstore_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STORE,
    ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin / fixed-priority channel picker
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  input  logic              rr_en,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int c;
      // Round-robin starts just past the previous winner and wraps.
      c = rr_en ? (int'(last_grant) + 1 + i) % NUM_CH : i;
      if (!grant_any && req[c]) begin
        grant[c]  = 1'b1;
        grant_idx = CH_W'(c);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dramstore_arbiter.sv
// rtl/dramstore_arbiter.sv - drains per-channel tile FIFOs into the DRAM store port
module dramstore_arbiter
  import sp_types_pkg::*;
#(
  parameter int          NUM_CH = 4,
  parameter int          ROWS   = 4,
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 64,
  parameter logic [31:0] STRIDE = SP_STRIDE,
  localparam int         ROW_W  = $clog2(ROWS),
  localparam int         CH_W   = $clog2(NUM_CH)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NUM_CH-1:0]        fifo_empty,
  input  logic [NUM_CH*ADDR_W-1:0] fifo_addr,
  input  logic [NUM_CH*ROW_W-1:0]  fifo_row,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        fifo_ren,
  input  logic                     rr_en,
  output logic                     sStore,
  output logic [ADDR_W-1:0]        store_addr,
  output logic [DATA_W-1:0]        store_data,
  input  logic                     sStore_hit,
  output logic                     store_complete,
  output logic [CH_W-1:0]          store_complete_ch,
  output logic                     row_err
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  arb_state_e        state;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   lock_ch;
  logic [ROW_W-1:0]  cap_row;
  logic [ROW_W-1:0]  exp_row;

  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  logic              tile_end;
  logic              rearb;
  logic              pop;
  logic [CH_W-1:0]   pop_ch;
  logic [ROW_W-1:0]  exp_cmp;
  logic [ADDR_W-1:0] sel_addr;
  logic [ROW_W-1:0]  sel_row;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req        (~fifo_empty),
    .last_grant (last_grant),
    .rr_en      (rr_en),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  always_comb begin
    tile_end = (state == ST_STORE) && sStore_hit && (cap_row == LAST_ROW);
    rearb    = (state == ST_IDLE) || tile_end;
    pop      = 1'b0;
    pop_ch   = lock_ch;
    fifo_ren = '0;
    if (rearb) begin
      pop    = arb_any;
      pop_ch = arb_idx;
      if (arb_any) fifo_ren = arb_grant;
    end else if ((state == ST_STORE && sStore_hit) || state == ST_WAIT) begin
      // Mid-tile: only the locked channel may feed the port.
      pop = !fifo_empty[lock_ch];
      if (pop) fifo_ren[lock_ch] = 1'b1;
    end
    // A new tile starting on the same edge as the old one ends expects row 0.
    exp_cmp  = tile_end ? '0 : exp_row;
    sel_addr = fifo_addr[pop_ch*ADDR_W +: ADDR_W];
    sel_row  = fifo_row[pop_ch*ROW_W +: ROW_W];
    sel_data = fifo_data[pop_ch*DATA_W +: DATA_W];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state             <= ST_IDLE;
      sStore            <= 1'b0;
      store_addr        <= '0;
      store_data        <= '0;
      store_complete    <= 1'b0;
      store_complete_ch <= '0;
      row_err           <= 1'b0;
      exp_row           <= '0;
      cap_row           <= '0;
      lock_ch           <= '0;
      last_grant        <= CH_W'(NUM_CH - 1);
    end else begin
      store_complete <= 1'b0;
      if (tile_end) begin
        store_complete    <= 1'b1;
        store_complete_ch <= lock_ch;
        exp_row           <= '0;
      end
      if (rearb && arb_any) begin
        lock_ch    <= arb_idx;
        last_grant <= arb_idx;
      end
      if (pop) begin
        store_addr <= sel_addr + ADDR_W'(STRIDE) * ADDR_W'(sel_row);
        store_data <= sel_data;
        cap_row    <= sel_row;
        sStore     <= 1'b1;
        state      <= ST_STORE;
        exp_row    <= (exp_cmp == LAST_ROW) ? '0 : exp_cmp + 1'b1;
        if (sel_row != exp_cmp) row_err <= 1'b1;
      end else if (state == ST_STORE && sStore_hit) begin
        sStore <= 1'b0;
        state  <= tile_end ? ST_IDLE : ST_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_dramstore_arbiter.sv
// tb/tb_dramstore_arbiter.sv - scoreboard bench for dramstore_arbiter
module tb_dramstore_arbiter;

  localparam int          NUM_CH = 4;
  localparam int          ROWS   = 4;
  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 64;
  localparam int          ROW_W  = 2;
  localparam int          CH_W   = 2;
  localparam logic [31:0] STRIDE = 32'd32;

  typedef struct { logic [31:0] addr; logic [ROW_W-1:0] row; logic [63:0] data; } ent_t;
  typedef struct { logic [31:0] addr; logic [63:0] data; } st_t;

  logic                     CLK = 1'b0;
  logic                     nRST = 1'b0;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*ADDR_W-1:0] fifo_addr;
  logic [NUM_CH*ROW_W-1:0]  fifo_row;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        fifo_ren;
  logic                     rr_en;
  logic                     sStore;
  logic [ADDR_W-1:0]        store_addr;
  logic [DATA_W-1:0]        store_data;
  logic                     sStore_hit;
  logic                     store_complete;
  logic [CH_W-1:0]          store_complete_ch;
  logic                     row_err;

  dramstore_arbiter #(
    .NUM_CH (NUM_CH), .ROWS (ROWS), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .STRIDE (STRIDE)
  ) dut (
    .CLK (CLK), .nRST (nRST),
    .fifo_empty (fifo_empty), .fifo_addr (fifo_addr), .fifo_row (fifo_row),
    .fifo_data (fifo_data), .fifo_ren (fifo_ren), .rr_en (rr_en),
    .sStore (sStore), .store_addr (store_addr), .store_data (store_data),
    .sStore_hit (sStore_hit), .store_complete (store_complete),
    .store_complete_ch (store_complete_ch), .row_err (row_err)
  );

  always #5 CLK = ~CLK;

  ent_t              chq[NUM_CH][$];
  logic [31:0]       pt_base[NUM_CH][$];
  logic [63:0]       pt_dat[NUM_CH][$];
  st_t               exp_st[$];
  int                exp_done[$];
  logic [NUM_CH-1:0] pend_ren = '0;
  int                nvec = 0, nerr = 0;
  int                mlast = NUM_CH - 1;
  bit                rnd_hit = 0, bp_on = 0;
  int                bp_cnt = 0, stall_seen = 0, run_len = 0, max_run = 0;
  logic [31:0]       bp_addr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_row(input int c, input logic [31:0] base, input int r, input logic [63:0] d);
    ent_t e;
    e.addr = base; e.row = ROW_W'(r); e.data = d;
    chq[c].push_back(e);
  endtask

  task automatic expect_row(input logic [31:0] base, input int r, input logic [63:0] d);
    st_t s;
    s.addr = base + STRIDE * r;
    s.data = d;
    exp_st.push_back(s);
  endtask

  task automatic expect_tile(input int c, input logic [31:0] base, input logic [63:0] d);
    for (int r = 0; r < ROWS; r++) expect_row(base, r, d + 64'(r));
    exp_done.push_back(c);
  endtask

  task automatic add_tile(input int c, input logic [31:0] base, input logic [63:0] d);
    for (int r = 0; r < ROWS; r++) push_row(c, base, r, d + 64'(r));
    pt_base[c].push_back(base);
    pt_dat[c].push_back(d);
  endtask

  // Tile-level reference: whole tiles are granted in arbitration order.
  task automatic plan();
    int pick;
    forever begin
      pick = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = rr_en ? (mlast + 1 + k) % NUM_CH : k;
        if (pick < 0 && pt_base[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      expect_tile(pick, pt_base[pick][0], pt_dat[pick][0]);
      pt_base[pick].delete(0);
      pt_dat[pick].delete(0);
      mlast = pick;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_st.size() != 0 || exp_done.size() != 0) && n < budget) begin
      @(negedge CLK); #2;
      n++;
    end
    nvec++;
    if (exp_st.size() != 0 || exp_done.size() != 0) begin
      nerr++;
      $display("FAIL drain_timeout: %0d stores and %0d completions outstanding, required 0",
               exp_st.size(), exp_done.size());
      exp_st.delete();
      exp_done.delete();
    end
    repeat (2) @(negedge CLK);
    #2;
  endtask

  // FIFO model and memory-side driver, updated just after each rising edge.
  initial begin
    sStore_hit = 1'b1;
    forever begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend_ren[c] && chq[c].size() > 0) chq[c].delete(0);
      end
      pend_ren = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        fifo_empty[c] = (chq[c].size() == 0);
        fifo_addr[c*ADDR_W +: ADDR_W] = fifo_empty[c] ? '0 : chq[c][0].addr;
        fifo_row[c*ROW_W +: ROW_W]    = fifo_empty[c] ? '0 : chq[c][0].row;
        fifo_data[c*DATA_W +: DATA_W] = fifo_empty[c] ? '0 : chq[c][0].data;
      end
      if (bp_on && sStore && store_addr == bp_addr && bp_cnt < 3) begin
        sStore_hit = 1'b0;
        bp_cnt++;
      end else begin
        sStore_hit = rnd_hit ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge CLK); #1;
    end
  end

  // Monitor: checks every handshake, completion and stall against the scoreboard.
  initial begin
    logic [31:0] pa;
    logic [63:0] pd;
    bit          stalled;
    st_t         e;
    int          ch;
    stalled = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        stalled = 0;
        run_len = 0;
        pend_ren = '0;
      end else begin
        if (stalled) begin
          chk("stall_addr", store_addr, pa);
          chk("stall_data", store_data, pd);
          chk("stall_req", sStore, 1'b1);
        end
        stalled = sStore && !sStore_hit;
        if (stalled) begin
          pa = store_addr;
          pd = store_data;
          stall_seen++;
          chk("stall_ren", fifo_ren, '0);
        end
        if (fifo_ren != '0) begin
          chk("ren_onehot", $countones(fifo_ren), 1);
          chk("ren_nonempty", fifo_ren & fifo_empty, '0);
        end
        pend_ren = fifo_ren;
        if (sStore && sStore_hit) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
          if (exp_st.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_store: addr %0h data %0h, required no store", store_addr, store_data);
          end else begin
            e = exp_st.pop_front();
            chk("store_addr", store_addr, e.addr);
            chk("store_data", store_data, e.data);
          end
        end else begin
          run_len = 0;
        end
        if (store_complete) begin
          if (exp_done.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_complete: ch %0d, required no completion", store_complete_ch);
          end else begin
            ch = exp_done.pop_front();
            chk("complete_ch", store_complete_ch, ch);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

  initial begin
    rr_en = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_sStore", sStore, 1'b0);
    chk("rst_addr", store_addr, '0);
    chk("rst_data", store_data, '0);
    chk("rst_complete", store_complete, 1'b0);
    chk("rst_complete_ch", store_complete_ch, '0);
    chk("rst_row_err", row_err, 1'b0);
    @(posedge CLK); #2;
    nRST = 1'b1;
    @(negedge CLK); #2;

    // Round-robin from reset: ch0, ch1, ch3, then ch0's second tile.
    add_tile(0, 32'h0000_1000, 64'h10);
    add_tile(1, 32'h0000_1100, 64'h20);
    add_tile(3, 32'h0000_1300, 64'h30);
    add_tile(0, 32'h0000_1800, 64'h40);
    plan();
    drain(200);

    // Single tile at full rate.
    max_run = 0;
    add_tile(0, 32'h0000_1000, 64'hA0);
    plan();
    drain(100);
    chk("single_burst_len", max_run, ROWS);
    chk("single_idle_req", sStore, 1'b0);

    // Fixed priority: ch0 repeats before ch1.
    rr_en = 1'b0;
    add_tile(1, 32'h0000_5100, 64'h50);
    add_tile(0, 32'h0000_5000, 64'h60);
    add_tile(0, 32'h0000_5800, 64'h70);
    plan();
    drain(200);
    rr_en = 1'b1;

    // Tile lock: ch2 stalls mid-tile while ch0 waits.
    push_row(2, 32'h0000_2000, 0, 64'hC0);
    push_row(2, 32'h0000_2000, 1, 64'hC1);
    expect_tile(2, 32'h0000_2000, 64'hC0);
    expect_tile(0, 32'h0000_2400, 64'hD0);
    for (int n = 0; n < 100 && exp_st.size() > 2 * ROWS - 2; n++) begin
      @(negedge CLK); #2;
    end
    chk("lock_first_rows", exp_st.size(), 2 * ROWS - 2);
    for (int r = 0; r < ROWS; r++) push_row(0, 32'h0000_2400, r, 64'hD0 + 64'(r));
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK); #2;
      chk("wait_sStore", sStore, 1'b0);
      chk("wait_no_pop", fifo_ren, '0);
    end
    push_row(2, 32'h0000_2000, 2, 64'hC2);
    push_row(2, 32'h0000_2000, 3, 64'hC3);
    mlast = 0;
    drain(200);

    // Backpressure on row 1.
    stall_seen = 0;
    bp_cnt = 0;
    bp_addr = 32'h0000_6000 + STRIDE;
    bp_on = 1;
    add_tile(1, 32'h0000_6000, 64'hE0);
    plan();
    drain(100);
    bp_on = 0;
    chk("stall_cycles", stall_seen, 3);

    // Randomized tiles, arbitration mode and backpressure.
    rnd_hit = 1;
    for (int it = 0; it < 20; it++) begin
      int total;
      total = 0;
      rr_en = 1'($urandom);
      for (int c = 0; c < NUM_CH; c++) begin
        int k;
        k = $urandom_range(0, 2);
        for (int t = 0; t < k; t++) add_tile(c, $urandom, {$urandom, $urandom});
        total += k;
      end
      if (total == 0) add_tile(int'($urandom_range(0, NUM_CH - 1)), $urandom, {$urandom, $urandom});
      plan();
      drain(2000);
    end
    rnd_hit = 0;
    rr_en = 1'b1;
    chk("row_err_clean", row_err, 1'b0);

    // Row sequence 0, 2, 3 raises a sticky row error.
    push_row(1, 32'h0000_3000, 0, 64'hF0);
    push_row(1, 32'h0000_3000, 2, 64'hF2);
    push_row(1, 32'h0000_3000, 3, 64'hF3);
    expect_row(32'h0000_3000, 0, 64'hF0);
    expect_row(32'h0000_3000, 2, 64'hF2);
    expect_row(32'h0000_3000, 3, 64'hF3);
    exp_done.push_back(1);
    mlast = 1;
    drain(100);
    chk("row_err_set", row_err, 1'b1);
    add_tile(3, 32'h0000_3300, 64'h33);
    plan();
    drain(100);
    chk("row_err_sticky", row_err, 1'b1);

    // Reset mid-tile, then the first grant must go to ch0.
    push_row(0, 32'h0000_4000, 0, 64'h90);
    push_row(0, 32'h0000_4000, 1, 64'h91);
    expect_row(32'h0000_4000, 0, 64'h90);
    expect_row(32'h0000_4000, 1, 64'h91);
    mlast = 0;
    drain(100);
    nRST = 1'b0;
    #1;
    chk("async_rst_sStore", sStore, 1'b0);
    chk("async_rst_row_err", row_err, 1'b0);
    chk("async_rst_addr", store_addr, '0);
    pend_ren = '0;
    for (int c = 0; c < NUM_CH; c++) chq[c].delete();
    exp_st.delete();
    exp_done.delete();
    mlast = NUM_CH - 1;
    add_tile(1, 32'h0000_7100, 64'h71);
    add_tile(0, 32'h0000_7000, 64'h70);
    plan();
    @(posedge CLK); #2;
    nRST = 1'b1;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
